// File: rtl/ctc_pkg.sv
// rtl/ctc_pkg.sv - word-cycle timing constants, instruction encodings and pointer-op helper
// Purpose: shared definitions for the Control & Timing sequencer.
// Contents: bit-time constants, ws field encodings, instruction type codes,
//           NOP word and the pointer update function.
package ctc_pkg;

  localparam logic [5:0] BT_LAST    = 6'd55;
  localparam logic [5:0] SYNC_FIRST = 6'd45;
  localparam logic [5:0] SYNC_LAST  = 6'd54;
  localparam logic [5:0] FETCH_BT   = 6'd44;
  localparam logic [3:0] DIGIT_MAX  = 4'd13;

  typedef enum logic [2:0] {
    FLD_P  = 3'b000,
    FLD_M  = 3'b001,
    FLD_X  = 3'b010,
    FLD_W  = 3'b011,
    FLD_WP = 3'b100,
    FLD_MS = 3'b101,
    FLD_XS = 3'b110,
    FLD_S  = 3'b111
  } field_e;

  localparam logic [1:0] IT_MISC   = 2'b00;
  localparam logic [1:0] IT_ARITH  = 2'b10;
  localparam logic [1:0] IT_BRANCH = 2'b11;

  localparam logic [1:0] PTR_SEL   = 2'b11;  // I[3:2] marking a pointer op within type 00
  localparam logic [9:0] NOP       = 10'h000;

  // New P after executing inst; returns p unchanged for non-pointer words.
  function automatic logic [3:0] ptr_update(input logic [9:0] inst, input logic [3:0] p);
    logic [3:0] r;
    r = p;
    if (inst[1:0] == IT_MISC && inst[3:2] == PTR_SEL) begin
      case (inst[5:4])
        2'b00:   r = (inst[9:6] > DIGIT_MAX) ? DIGIT_MAX : inst[9:6];
        2'b01:   r = (p >= DIGIT_MAX) ? 4'd0 : p + 4'd1;
        2'b10:   r = (p == 4'd0) ? DIGIT_MAX : p - 4'd1;
        default: r = p;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ctc_ws_gen.sv
// rtl/ctc_ws_gen.sv - registered word-select generator
// Purpose: decodes the word-select field against the digit index of the
//          coming bit time and registers the result, so ws is glitch-free
//          and changes only on digit boundaries.
// Ports: cph2/rst clock and sync active-high reset; en arith instruction
//        executing next; fld field of that instruction; p pointer value for
//        the next bit time; d next digit index; ws registered word select.
module ctc_ws_gen
  import ctc_pkg::*;
(
  input  logic       cph2,
  input  logic       rst,
  input  logic       en,
  input  field_e     fld,
  input  logic [3:0] p,
  input  logic [3:0] d,
  output logic       ws
);

  logic hit;

  always_comb begin
    hit = 1'b0;
    case (fld)
      FLD_P:  hit = (d == p);
      FLD_M:  hit = (d >= 4'd3) && (d <= 4'd12);
      FLD_X:  hit = (d <= 4'd1);
      FLD_W:  hit = (d <= DIGIT_MAX);
      FLD_WP: hit = (d <= p);
      FLD_MS: hit = (d >= 4'd3) && (d <= DIGIT_MAX);
      FLD_XS: hit = (d == 4'd2);
      FLD_S:  hit = (d == DIGIT_MAX);
    endcase
  end

  always_ff @(posedge cph2) begin
    if (rst) ws <= 1'b0;
    else     ws <= en & hit;
  end

endmodule

// File: rtl/ctc_sequencer.sv
// rtl/ctc_sequencer.sv - word-cycle sequencer: bit timing, instruction issue, ws, pointer, branch
// Purpose: counts 56 bit times per word, fetches at bt 44, serialises the
//          instruction LSB-first on is during bt 45..54 with sync, executes
//          it in the following word (ws, pointer ops, branch test).
// Ports: cph2 clock; rst sync active-high reset; inst_data/inst_valid/
//        inst_ready fetch handshake; sync/is serial issue; ws word select;
//        carry A&R carry line; start bt-0 marker; p digit pointer;
//        carry_flag sampled carry; cond_taken branch pulse at bt 55.
// Option: CTC_CARRY_BRANCH_EN builds carry sampling and branch evaluation.
module ctc_sequencer
  import ctc_pkg::*;
(
  input  logic       cph2,
  input  logic       rst,
  input  logic [9:0] inst_data,
  input  logic       inst_valid,
  output logic       inst_ready,
  output logic       sync,
  output logic       is,
  output logic       ws,
  input  logic       carry,
  output logic       start,
  output logic [3:0] p,
  output logic       carry_flag,
  output logic       cond_taken
);

  logic [5:0] bt, bt_next;
  logic [9:0] issue_q, exec_q, exec_next;
  logic [3:0] p_q, p_next;
  logic [3:0] is_idx;
  logic       word_end;

  assign word_end  = (bt == BT_LAST);
  assign bt_next   = word_end ? 6'd0 : bt + 6'd1;
  assign exec_next = word_end ? issue_q : exec_q;
  assign p_next    = word_end ? ptr_update(exec_q, p_q) : p_q;

  always_ff @(posedge cph2) begin
    if (rst) begin
      bt      <= 6'd0;
      issue_q <= NOP;
      exec_q  <= NOP;
      p_q     <= 4'd0;
    end else begin
      bt     <= bt_next;
      exec_q <= exec_next;
      p_q    <= p_next;
      if (bt == FETCH_BT)
        issue_q <= inst_valid ? inst_data : NOP;
    end
  end

  assign start      = (bt == 6'd0);
  assign inst_ready = (bt == FETCH_BT);
  assign sync       = (bt >= SYNC_FIRST) && (bt <= SYNC_LAST);
  // 45 mod 16 = 13, so the low nibble minus 13 gives bit 0..9 across the sync window.
  assign is_idx     = bt[3:0] - 4'd13;
  assign is         = sync ? issue_q[is_idx] : 1'b0;
  assign p          = p_q;

  // ws is computed from the values that will hold in the next bit time, so the
  // first digit of a new word already reflects the new instruction and new P.
  ctc_ws_gen u_ws_gen (
    .cph2 (cph2),
    .rst  (rst),
    .en   (exec_next[1:0] == IT_ARITH),
    .fld  (field_e'(exec_next[4:2])),
    .p    (p_next),
    .d    (bt_next[5:2]),
    .ws   (ws)
  );

`ifdef CTC_CARRY_BRANCH_EN
  logic carry_q;

  always_ff @(posedge cph2) begin
    if (rst)               carry_q <= 1'b0;
    else if (bt == 6'd0)   carry_q <= carry;
  end

  assign carry_flag = carry_q;
  assign cond_taken = word_end && (exec_q[1:0] == IT_BRANCH) && !carry_q;
`else
  logic unused_carry;
  assign unused_carry = carry;
  assign carry_flag   = 1'b0;
  assign cond_taken   = 1'b0;
`endif

endmodule

// File: tb/tb_ctc_sequencer.sv
// tb/tb_ctc_sequencer.sv - directed self-checking bench for ctc_sequencer
module tb_ctc_sequencer;

  logic       cph2 = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] inst_data = 10'h000;
  logic       inst_valid = 1'b0;
  logic       inst_ready, sync, is, ws, start, carry_flag, cond_taken;
  logic       carry = 1'b0;
  logic [3:0] p;

  int total = 0;
  int bad = 0;
  int mbt = 0;

`ifdef CTC_CARRY_BRANCH_EN
  localparam logic BR_EN = 1'b1;
`else
  localparam logic BR_EN = 1'b0;
`endif

  ctc_sequencer dut (
    .cph2       (cph2),
    .rst        (rst),
    .inst_data  (inst_data),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .sync       (sync),
    .is         (is),
    .ws         (ws),
    .carry      (carry),
    .start      (start),
    .p          (p),
    .carry_flag (carry_flag),
    .cond_taken (cond_taken)
  );

  always #5 cph2 = ~cph2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cph2);
    #1;
    mbt = (mbt == 55) ? 0 : mbt + 1;
  endtask

  function automatic logic [55:0] mask(input int lo, input int hi);
    logic [55:0] m;
    m = '0;
    for (int b = 0; b < 56; b++)
      if (b >= lo && b <= hi) m[b] = 1'b1;
    return m;
  endfunction

  // One full word cycle from bt 0 to the next bt 0. inst_valid is held high
  // with junk data outside bt 44 so stray captures would show up.
  task automatic run_cycle(input string tag, input logic [9:0] w, input logic v, input logic cin,
                           output logic [55:0] ws_o, output logic [9:0] is_o,
                           output logic ct_o, output logic cf_o);
    int ctrl_bad;
    logic e_start, e_sync, e_rdy;
    ctrl_bad = 0;
    ws_o = '0; is_o = '0; ct_o = 1'b0; cf_o = 1'b0;
    for (int b = 0; b < 56; b++) begin
      carry      = (b == 0) ? cin : ~cin;
      inst_valid = (b == 44) ? v : 1'b1;
      inst_data  = (b == 44) ? w : 10'h3FF;
      e_start = (b == 0);
      e_sync  = (b >= 45 && b <= 54);
      e_rdy   = (b == 44);
      if (start !== e_start || sync !== e_sync || inst_ready !== e_rdy) ctrl_bad++;
      if (!e_sync && is !== 1'b0) ctrl_bad++;
      ws_o[b] = ws;
      if (e_sync) is_o[b-45] = is;
      if (b == 55) ct_o = cond_taken;
      if (b == 1) cf_o = carry_flag;
      step();
    end
    check({tag, "_ctrl"}, ctrl_bad, 0);
  endtask

  logic [55:0] ws_o;
  logic [9:0]  is_o;
  logic        ct_o, cf_o;

  initial begin
    // Reset
    @(posedge cph2); #1;
    @(posedge cph2); #1;
    check("rst_out", {start, sync, is, ws, inst_ready, cond_taken, carry_flag}, 7'b1000000);
    check("rst_p", p, 0);
    rst = 1'b0;
    mbt = 0;

    // Free run with invalid fetch: NOP issued
    run_cycle("c0", 10'h155, 1'b0, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("c0_is", is_o, 10'h000);
    check("c0_ws", ws_o, 56'h0);

    // Serialise 1011001110 (W arith)
    run_cycle("c1", 10'h2CE, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("c1_is", is_o, 10'h2CE);
    check("c1_ws", ws_o, 56'h0);

    // Exec W: ws all word; fetch P=5
    run_cycle("c2", 10'h14C, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("c2_is", is_o, 10'h14C);
    check("c2_ws_w", ws_o, mask(0, 55));

    // Exec P=5; fetch WP arith
    run_cycle("c3", 10'h012, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("c3_ws", ws_o, 56'h0);
    check("p_set5", p, 5);

    // Exec WP with P=5 -> digits 0..5
    run_cycle("c4", 10'h00C, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("c4_ws_wp", ws_o, mask(0, 23));
    check("p_hold5", p, 5);

    // P=0, P-1 -> 13, P=13, P+1 -> 0, P=15 -> 13
    run_cycle("c5", 10'h02C, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("p_set0", p, 0);
    run_cycle("c6", 10'h34C, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("p_dec_wrap", p, 13);
    run_cycle("c7", 10'h01C, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("p_set13", p, 13);
    run_cycle("c8", 10'h3CC, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("p_inc_wrap", p, 0);
    run_cycle("c9", 10'h003, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("p_sat15", p, 13);

    // Branch executing with carry 0, then with carry 1
    run_cycle("c10", 10'h003, 1'b1, 1'b0, ws_o, is_o, ct_o, cf_o);
    check("br_c0_cf", cf_o, 0);
    check("br_c0_taken", ct_o, BR_EN);
    check("br_ws", ws_o, 56'h0);
    run_cycle("c11", 10'h01E, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("br_c1_cf", cf_o, BR_EN);
    check("br_c1_taken", ct_o, 0);

    // Exec S (digit 13); fetch M
    run_cycle("c12", 10'h006, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("ws_s", ws_o, mask(52, 55));
    check("nobr_taken", ct_o, 0);
    // Exec M (digits 3..12); fetch W
    run_cycle("c13", 10'h00E, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("ws_m", ws_o, mask(12, 51));

    // Mid-cycle reset while W executes and P=5 sits in the issue stage
    for (int b = 0; b < 50; b++) begin
      carry      = 1'b1;
      inst_valid = 1'b1;
      inst_data  = (b == 44) ? 10'h14C : 10'h3FF;
      if (b == 20) check("pre_rst_ws", ws, 1);
      step();
    end
    check("pre_rst_sync", sync, 1);
    rst = 1'b1;
    @(posedge cph2); #1;
    check("mid_rst_out", {start, sync, is, ws, inst_ready, cond_taken, carry_flag}, 7'b1000000);
    check("mid_rst_p", p, 0);
    rst = 1'b0;
    mbt = 0;

    run_cycle("r0", 10'h2CE, 1'b1, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("r0_is", is_o, 10'h2CE);
    check("r0_ws_flushed", ws_o, 56'h0);
    check("r0_p", p, 0);
    run_cycle("r1", 10'h000, 1'b0, 1'b1, ws_o, is_o, ct_o, cf_o);
    check("r1_ws_w", ws_o, mask(0, 55));
    check("r1_is", is_o, 10'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
